pic_int_sequencer: RTL and testbench
====================================

# pic_int_sequencer

Control and sequencing block for the 8259A-style interrupt controller. It owns the IRR, ISR and IMR registers and resolves priority, with fully nested mode and a rotating priority pointer. It drives the INT request and runs the two-pulse INTA acknowledge sequence, placing the interrupt vector on the data bus. It also executes EOI and rotation commands written by the CPU interface.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- ir  in  8  interrupt request lines, synchronous to clk
- ltim  in  1  1 = level-triggered, 0 = edge-triggered IRR capture
- aeoi  in  1  1 = automatic EOI at end of second INTA
- wr_strobe  in  1  one-cycle register write strobe
- wr_sel  in  2  00 = IMR, 01 = vector base (wr_data[7:3]), 10 = OCW2 command, 11 = ignored
- wr_data  in  8  write data
- inta  in  1  one-cycle strobe per CPU acknowledge pulse
- int_out  out  1  interrupt request to CPU
- data_out  out  8  vector byte
- data_oe  out  1  data_out valid / bus drive enable
- irr  out  8  interrupt request register
- isr  out  8  in-service register
- imr  out  8  interrupt mask register

## Operation
- Reset values: irr, isr, imr, data_out = 0; vector base = 0; int_out, data_oe = 0; priority pointer lo_pri = 7 (IR0 highest); FSM in IDLE.
- IRR capture (per bit):
  - Edge mode: set when ir=1 and ir_d=0, where ir_d is ir registered by one clk.
  - Level mode: set while ir=1 and cleared while ir=0.
  - Either mode: the bit is cleared on transfer to ISR. Set wins over clear only in edge mode when a new edge coincides with the transfer.
- Priority order: starts at (lo_pri+1) mod 8 and proceeds with wrap. cand is the highest-priority set bit of irr & ~imr; cand_valid is true if any such bit exists.
- Nesting: req = cand_valid and (isr==0, or cand strictly higher priority than the highest-priority ISR bit). Masked ISR bits still block lower levels.
- FSM:
  - IDLE: go to PEND when req=1. An inta strobe in IDLE is ignored.
  - PEND: int_out=1.
    - If req drops before inta: return to IDLE and deassert int_out.
    - On inta with cand_valid: isr[cand]←1, irr[cand]←0, latch id=cand, go to ACK1.
    - On inta with no candidate (spurious): id=7, ISR unchanged, go to ACK1.
  - ACK1: int_out=0. On inta: data_out←{base, id}, data_oe←1.
    - If aeoi and not spurious: clear isr[id].
    - Go to IDLE.
- OCW2 (wr_sel=10, cmd=wr_data[7:5], L=wr_data[2:0]):
  - 001 non-specific EOI: clear the highest-priority ISR bit.
  - 011 specific EOI: clear isr[L].
  - 101 rotate on non-specific EOI: clear the highest-priority ISR bit h; set lo_pri←h.
  - 111 rotate on specific EOI: clear isr[L]; set lo_pri←L.
  - 110 set priority: lo_pri←L.
  - Other codes are no-ops. Non-specific commands with isr==0 are no-ops and do not rotate.
- Simultaneous EOI write and inta ISR set in the same cycle:
  - EOI is evaluated on the pre-edge ISR; the new ISR bit from inta is retained.
  - If both target the same bit, the inta set wins.
- An IMR write takes effect for cand on the next cycle. Masking the pending cand while in PEND drops req, so the FSM returns to IDLE.
- Reset asserted mid-sequence: immediate return to reset values on that edge. Any acknowledge in progress is abandoned.

## Timing
- Edge mode: ir rising before edge k → irr bit visible after edge k → int_out high after edge k+1.
- Level mode: same latency as edge mode.
- First inta sampled at edge m → int_out low and isr bit visible after edge m.
- Second inta sampled at edge n → data_oe=1 for exactly the cycle after edge n, then 0 after edge n+1.
  - data_out holds its value until the next vector.
  - With aeoi, the ISR bit clears at edge n.
- OCW2 and IMR writes update state at the strobe edge. A priority change affects cand in the following cycle.
- The next request can assert int_out no earlier than 1 cycle after returning to IDLE.

## Test plan
- Basic edge: base=5'h08, imr=0, pulse ir[3] → int_out rises 2 cycles later. Two inta pulses → isr=8'h08, data_out=8'h43 with data_oe one cycle. OCW2 8'h20 → isr=0.
- Nesting: ISR holds IR3, ir[5] rises → no int_out. Then ir[1] rises → int_out. After acks, isr=8'h0A. Non-specific EOI clears bit1 first.
- Rotation: IR2 acked, then OCW2 8'hA0 → lo_pri=2. Assert ir[1] and ir[4] together → IR4 serviced first (vector id 4).
- Spurious: level mode, ir[6] high, int_out high, ir[6] drops before first inta. FSM returns to IDLE and int_out falls. Force inta during PEND after ir drops in same cycle → vector id 7, isr unchanged.
- AEOI + mask: aeoi=1, imr=8'hFE, ir[0] and ir[1] rise → only IR0 serviced. isr=0 after second inta. ir[1] stays pending in irr=8'h02.
- Reset mid-ack: assert reset in ACK1 → all outputs 0, lo_pri=7. A later second inta is ignored and data_oe stays 0.

Source files
------------

// File: rtl/pic_int_sequencer_if.sv
// Signal bundle between the CPU-side logic and the interrupt sequencer.
// No logic: the sequencer owns every output and registers its own state.
// No backpressure; one-cycle strobes (wr_strobe, inta) are consumed when sampled.
//   master: drives request lines, mode pins, register writes and inta strobes
//   slave : returns int_out, the vector bus and the irr/isr/imr registers
interface pic_int_sequencer_if;
    logic [7:0] ir;
    logic       ltim;
    logic       aeoi;
    logic       wr_strobe;
    logic [1:0] wr_sel;
    logic [7:0] wr_data;
    logic       inta;
    logic       int_out;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] irr;
    logic [7:0] isr;
    logic [7:0] imr;

    modport master (
        output ir, ltim, aeoi, wr_strobe, wr_sel, wr_data, inta,
        input  int_out, data_out, data_oe, irr, isr, imr
    );

    modport slave (
        input  ir, ltim, aeoi, wr_strobe, wr_sel, wr_data, inta,
        output int_out, data_out, data_oe, irr, isr, imr
    );
endinterface

// File: rtl/pic_int_sequencer.sv
// 8259A-style IRR/ISR/IMR owner with rotating priority, nesting and the INTA sequence.
// Latency: ir edge -> irr next edge -> int_out one edge later; vector one cycle after 2nd inta.
// No backpressure: writes and inta strobes act on the edge they are sampled.
//   clk, reset : clock and synchronous active-high reset
//   bus (slave): ir/ltim/aeoi/wr_*/inta in; int_out/data_out/data_oe/irr/isr/imr out
module pic_int_sequencer (
    input  logic                 clk,
    input  logic                 reset,
    pic_int_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, PEND, ACK1} state_t;

    state_t     state;
    state_t     state_nxt;

    logic [7:0] irr_q;
    logic [7:0] isr_q;
    logic [7:0] imr_q;
    logic [7:0] ir_d;
    logic [7:0] data_q;
    logic       oe_q;
    logic [4:0] base_q;
    logic [2:0] lo_pri;
    logic [2:0] id_q;
    logic       spur_q;

    // Priority resolution over the rotated order lo_pri+1, lo_pri+2, ...
    logic [7:0] req_bits;
    logic [2:0] scan_idx;
    logic [2:0] cand;
    logic [2:0] cand_rank;
    logic       cand_valid;
    logic [2:0] isr_top;
    logic [2:0] top_rank;
    logic       isr_any;
    logic       req;

    assign req_bits = irr_q & ~imr_q;

    always_comb begin
        scan_idx   = 3'd0;
        cand       = 3'd0;
        cand_rank  = 3'd0;
        cand_valid = 1'b0;
        isr_top    = 3'd0;
        top_rank   = 3'd0;
        isr_any    = 1'b0;
        for (int k = 0; k < 8; k++) begin
            scan_idx = lo_pri + 3'(k) + 3'd1;
            if (!cand_valid && req_bits[scan_idx]) begin
                cand       = scan_idx;
                cand_rank  = 3'(k);
                cand_valid = 1'b1;
            end
            if (!isr_any && isr_q[scan_idx]) begin
                isr_top  = scan_idx;
                top_rank = 3'(k);
                isr_any  = 1'b1;
            end
        end
    end

    // Masked ISR bits still count in isr_top, so they keep blocking lower levels.
    assign req = cand_valid && (!isr_any || (cand_rank < top_rank));

    // Acknowledge FSM
    logic ack_take;
    logic ack_spur;
    logic vec_issue;

    always_comb begin
        state_nxt = state;
        ack_take  = 1'b0;
        ack_spur  = 1'b0;
        vec_issue = 1'b0;
        case (state)
            IDLE: begin
                if (req) state_nxt = PEND;
            end
            PEND: begin
                // inta has priority over a dropping req: a late pulse gets the spurious vector.
                if (bus.inta) begin
                    state_nxt = ACK1;
                    if (cand_valid) ack_take = 1'b1;
                    else            ack_spur = 1'b1;
                end else if (!req) begin
                    state_nxt = IDLE;
                end
            end
            ACK1: begin
                if (bus.inta) begin
                    vec_issue = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // OCW2 decode; non-specific forms act on the pre-edge ISR.
    logic       ocw_wr;
    logic [2:0] ocw_cmd;
    logic [2:0] ocw_lvl;
    logic [7:0] eoi_clr;
    logic [2:0] lo_pri_nxt;

    assign ocw_wr  = bus.wr_strobe && (bus.wr_sel == 2'b10);
    assign ocw_cmd = bus.wr_data[7:5];
    assign ocw_lvl = bus.wr_data[2:0];

    always_comb begin
        eoi_clr    = 8'h00;
        lo_pri_nxt = lo_pri;
        if (ocw_wr) begin
            case (ocw_cmd)
                3'b001: if (isr_any) eoi_clr = 8'(1) << isr_top;
                3'b011: eoi_clr = 8'(1) << ocw_lvl;
                3'b101: if (isr_any) begin
                    eoi_clr    = 8'(1) << isr_top;
                    lo_pri_nxt = isr_top;
                end
                3'b111: begin
                    eoi_clr    = 8'(1) << ocw_lvl;
                    lo_pri_nxt = ocw_lvl;
                end
                3'b110: lo_pri_nxt = ocw_lvl;
                default: ;
            endcase
        end
    end

    // ISR/IRR next state. The inta set is OR-ed after all clears so it wins a collision.
    logic [7:0] aeoi_clr;
    logic [7:0] isr_set;
    logic [7:0] isr_nxt;
    logic [7:0] irr_nxt;
    logic [7:0] ir_rise;

    assign aeoi_clr = (vec_issue && bus.aeoi && !spur_q) ? (8'(1) << id_q) : 8'h00;
    assign isr_set  = ack_take ? (8'(1) << cand) : 8'h00;
    assign isr_nxt  = (isr_q & ~(eoi_clr | aeoi_clr)) | isr_set;
    assign ir_rise  = bus.ir & ~ir_d;
    // Level mode follows ir; edge mode holds until transfer, a fresh edge beating the clear.
    assign irr_nxt  = bus.ltim ? (bus.ir & ~isr_set) : (ir_rise | (irr_q & ~isr_set));

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            irr_q  <= 8'h00;
            isr_q  <= 8'h00;
            imr_q  <= 8'h00;
            ir_d   <= 8'h00;
            data_q <= 8'h00;
            oe_q   <= 1'b0;
            base_q <= 5'd0;
            lo_pri <= 3'd7;
            id_q   <= 3'd0;
            spur_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            irr_q  <= irr_nxt;
            isr_q  <= isr_nxt;
            ir_d   <= bus.ir;
            oe_q   <= vec_issue;
            lo_pri <= lo_pri_nxt;
            if (vec_issue)
                data_q <= {base_q, id_q};
            if (ack_take || ack_spur) begin
                id_q   <= ack_take ? cand : 3'd7;
                spur_q <= ack_spur;
            end
            if (bus.wr_strobe && bus.wr_sel == 2'b00)
                imr_q <= bus.wr_data;
            if (bus.wr_strobe && bus.wr_sel == 2'b01)
                base_q <= bus.wr_data[7:3];
        end
    end

    assign bus.int_out  = (state == PEND);
    assign bus.data_out = data_q;
    assign bus.data_oe  = oe_q;
    assign bus.irr      = irr_q;
    assign bus.isr      = isr_q;
    assign bus.imr      = imr_q;

endmodule

// File: tb/tb_pic_int_sequencer.sv
// Self-checking bench for pic_int_sequencer: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model built from priority ranks.
// Inputs change #1 after the rising edge; outputs are sampled at that same point.
module tb_pic_int_sequencer;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    pic_int_sequencer_if bus();

    pic_int_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] m_irr = 8'h00, m_isr = 8'h00, m_imr = 8'h00, m_ird = 8'h00;
    logic [7:0] m_dout = 8'h00;
    logic       m_oe = 1'b0;
    logic [4:0] m_base = 5'd0;
    logic [2:0] m_lo = 3'd7;
    logic [2:0] m_id = 3'd0;
    logic       m_spur = 1'b0;
    logic       m_int = 1'b0;      // int_out currently asserted
    logic       m_wait2 = 1'b0;    // first pulse taken, awaiting the vector pulse

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Distance from the highest-priority slot; 0 is the top level.
    function automatic int rank(input int i);
        return (i - int'(m_lo) - 1 + 16) % 8;
    endfunction

    task automatic step();
        int         cb, tb;
        logic       rq;
        logic [7:0] set_b, clr_b, n_irr, n_isr, n_imr, n_dout;
        logic [4:0] n_base;
        logic [2:0] n_lo, n_id, l;
        logic       n_oe, n_spur, n_int, n_wait2;

        cb = -1; tb = -1;
        for (int i = 0; i < 8; i++) begin
            if (m_irr[i] && !m_imr[i] && (cb < 0 || rank(i) < rank(cb))) cb = i;
            if (m_isr[i] && (tb < 0 || rank(i) < rank(tb))) tb = i;
        end
        rq = (cb >= 0) && (tb < 0 || rank(cb) < rank(tb));

        set_b = 0; clr_b = 0;
        n_imr = m_imr; n_dout = m_dout; n_base = m_base; n_lo = m_lo;
        n_id = m_id; n_spur = m_spur; n_int = m_int; n_wait2 = m_wait2; n_oe = 0;

        if (m_wait2) begin
            if (bus.inta) begin
                n_dout = {m_base, m_id};
                n_oe = 1;
                if (bus.aeoi && !m_spur) clr_b[m_id] = 1;
                n_wait2 = 0;
            end
        end else if (m_int) begin
            if (bus.inta) begin
                n_int = 0; n_wait2 = 1;
                if (cb >= 0) begin set_b[cb] = 1; n_id = 3'(cb); n_spur = 0; end
                else begin n_id = 3'd7; n_spur = 1; end
            end else if (!rq) n_int = 0;
        end else if (rq) n_int = 1;

        if (bus.wr_strobe) begin
            l = bus.wr_data[2:0];
            case (bus.wr_sel)
                2'd0: n_imr = bus.wr_data;
                2'd1: n_base = bus.wr_data[7:3];
                2'd2: case (bus.wr_data[7:5])
                    3'd1: if (tb >= 0) clr_b[tb] = 1;
                    3'd3: clr_b[l] = 1;
                    3'd5: if (tb >= 0) begin clr_b[tb] = 1; n_lo = 3'(tb); end
                    3'd7: begin clr_b[l] = 1; n_lo = l; end
                    3'd6: n_lo = l;
                    default: ;
                endcase
                default: ;
            endcase
        end

        for (int i = 0; i < 8; i++) begin
            if (bus.ltim) n_irr[i] = bus.ir[i] && !set_b[i];
            else          n_irr[i] = (bus.ir[i] && !m_ird[i]) || (m_irr[i] && !set_b[i]);
        end
        n_isr = (m_isr & ~clr_b) | set_b;

        @(posedge clk);
        #1;
        if (reset) begin
            m_irr = 0; m_isr = 0; m_imr = 0; m_ird = 0; m_dout = 0; m_oe = 0;
            m_base = 0; m_lo = 3'd7; m_id = 0; m_spur = 0; m_int = 0; m_wait2 = 0;
        end else begin
            m_irr = n_irr; m_isr = n_isr; m_imr = n_imr; m_ird = bus.ir; m_dout = n_dout;
            m_oe = n_oe; m_base = n_base; m_lo = n_lo; m_id = n_id; m_spur = n_spur;
            m_int = n_int; m_wait2 = n_wait2;
        end
        chk("int_out",  {7'd0, bus.int_out}, {7'd0, m_int});
        chk("data_oe",  {7'd0, bus.data_oe}, {7'd0, m_oe});
        chk("data_out", bus.data_out, m_dout);
        chk("irr",      bus.irr, m_irr);
        chk("isr",      bus.isr, m_isr);
        chk("imr",      bus.imr, m_imr);
        bus.wr_strobe = 1'b0;
        bus.inta      = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [7:0] d);
        bus.wr_strobe = 1'b1;
        bus.wr_sel    = sel;
        bus.wr_data   = d;
        step();
    endtask

    task automatic ack();
        bus.inta = 1'b1;
        step();
    endtask

    task automatic pulse_ir(input logic [7:0] v);
        bus.ir = v;
        step();
        bus.ir = 8'h00;
        step();
    endtask

    task automatic wait_int(input int budget);
        int n;
        n = 0;
        while (!bus.int_out && n < budget) begin
            step();
            n++;
        end
        chk("wait_int", {7'd0, bus.int_out}, 8'h01);
    endtask

    initial begin
        reset = 1'b1;
        bus.ir = 8'h00; bus.ltim = 1'b0; bus.aeoi = 1'b0;
        bus.wr_strobe = 1'b0; bus.wr_sel = 2'b00; bus.wr_data = 8'h00; bus.inta = 1'b0;
        #1;
        step();
        do_reset();
        chk("rst_int", {7'd0, bus.int_out}, 8'h00);
        chk("rst_isr", bus.isr, 8'h00);
        chk("rst_dout", bus.data_out, 8'h00);

        // Basic edge-triggered sequence
        wr(2'b01, 8'h40);
        wr(2'b00, 8'h00);
        bus.ir = 8'h08;
        step();
        chk("basic_irr", bus.irr, 8'h08);
        chk("basic_int_early", {7'd0, bus.int_out}, 8'h00);
        bus.ir = 8'h00;
        step();
        chk("basic_int", {7'd0, bus.int_out}, 8'h01);
        ack();
        chk("basic_isr", bus.isr, 8'h08);
        chk("basic_int_low", {7'd0, bus.int_out}, 8'h00);
        ack();
        chk("basic_vec", bus.data_out, 8'h43);
        chk("basic_oe", {7'd0, bus.data_oe}, 8'h01);
        step();
        chk("basic_oe_off", {7'd0, bus.data_oe}, 8'h00);
        chk("basic_vec_hold", bus.data_out, 8'h43);
        wr(2'b10, 8'h20);
        chk("basic_eoi", bus.isr, 8'h00);

        // Nesting
        do_reset();
        pulse_ir(8'h08);
        ack(); ack();
        pulse_ir(8'h20);
        step();
        chk("nest_block", {7'd0, bus.int_out}, 8'h00);
        pulse_ir(8'h02);
        chk("nest_int", {7'd0, bus.int_out}, 8'h01);
        ack(); ack();
        chk("nest_isr", bus.isr, 8'h0A);
        wr(2'b10, 8'h20);
        chk("nest_eoi", bus.isr, 8'h08);

        // Rotation on non-specific EOI
        do_reset();
        pulse_ir(8'h04);
        ack(); ack();
        wr(2'b10, 8'hA0);
        chk("rot_isr", bus.isr, 8'h00);
        pulse_ir(8'h12);
        ack(); ack();
        chk("rot_vec", bus.data_out, 8'h04);
        chk("rot_isr4", bus.isr, 8'h10);

        // Spurious / dropped level request
        do_reset();
        bus.ltim = 1'b1;
        bus.ir = 8'h40;
        wait_int(5);
        bus.ir = 8'h00;
        step(); step();
        chk("spur_drop", {7'd0, bus.int_out}, 8'h00);
        bus.ir = 8'h40;
        wait_int(5);
        bus.ir = 8'h00;
        step();
        ack();
        chk("spur_isr", bus.isr, 8'h00);
        ack();
        chk("spur_vec", bus.data_out, 8'h07);
        bus.ltim = 1'b0;

        // AEOI with masking
        do_reset();
        bus.aeoi = 1'b1;
        wr(2'b00, 8'hFE);
        bus.ir = 8'h03;
        step();
        bus.ir = 8'h00;
        wait_int(5);
        ack();
        chk("aeoi_isr1", bus.isr, 8'h01);
        ack();
        chk("aeoi_isr0", bus.isr, 8'h00);
        chk("aeoi_irr", bus.irr, 8'h02);
        chk("aeoi_vec", bus.data_out, 8'h00);
        bus.aeoi = 1'b0;

        // Reset during acknowledge
        do_reset();
        wr(2'b10, 8'hC0);
        pulse_ir(8'h08);
        ack();
        do_reset();
        chk("rack_int", {7'd0, bus.int_out}, 8'h00);
        chk("rack_isr", bus.isr, 8'h00);
        chk("rack_oe", {7'd0, bus.data_oe}, 8'h00);
        ack();
        chk("rack_inta_ignored", {7'd0, bus.data_oe}, 8'h00);
        pulse_ir(8'h03);
        ack(); ack();
        chk("rack_lopri", bus.data_out, 8'h00);

        // Randomized traffic
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 250 == 0) begin
                bus.ltim = 1'($urandom_range(0, 1));
                bus.aeoi = 1'($urandom_range(0, 1));
            end
            if (bus.ltim) begin
                if ($urandom_range(0, 3) == 0) bus.ir = 8'($urandom);
            end else begin
                bus.ir = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            end
            bus.inta = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) begin
                bus.wr_strobe = 1'b1;
                bus.wr_sel    = 2'($urandom_range(0, 3));
                bus.wr_data   = (bus.wr_sel == 2'b00) ? 8'($urandom & $urandom & $urandom)
                                                      : 8'($urandom);
            end
            reset = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
